timed_bcd_counter: RTL and testbench
====================================

Name: timed_bcd_counter

Overview:
- Parametrised multi-digit BCD timer/counter: a prescaler divides i_Clk into a step tick, and an N-digit BCD count advances once per tick.
- Adds up/down mode, enable/pause, synchronous clear, parallel load, and tick/rollover pulses.
- Sits between the board clock and the seven-segment display drivers.
- Is the general-purpose time base for stopwatch/countdown style top levels.

Parameters:
- CYCLES_PER_TICK, 25000000, i_Clk cycles per count step; legal range >= 1.
- NUM_DIGITS, 2, number of BCD digits; legal range 1..8.

Ports:
- i_Clk  input  1  system clock, all state on rising edge.
- i_Reset  input  1  asynchronous, active-high reset.
- i_Enable  input  1  1 = prescaler runs; 0 = pause, all state held.
- i_Up  input  1  1 = count up, 0 = count down; sampled on tick cycles only.
- i_Clear  input  1  synchronous clear of count and prescaler.
- i_Load  input  1  synchronous parallel load.
- i_Load_Value  input  4*NUM_DIGITS  BCD load value; digit k occupies bits [4k+3:4k], digit 0 is least significant.
- o_Count  output  4*NUM_DIGITS  current BCD count, same digit packing as i_Load_Value.
- o_Tick  output  1  one-cycle pulse, high in the same cycle o_Count first shows a stepped value.
- o_Wrap  output  1  one-cycle pulse marking a rollover (up 99..9->00..0, down 00..0->99..9); coincides with o_Tick.

Behaviour:
- Reset (async assert, released synchronously by i_Clk):
  - prescaler = 0; o_Count = all zeros; o_Tick = 0; o_Wrap = 0.
- Prescaler:
  - Width $clog2(CYCLES_PER_TICK), minimum 1 bit.
  - When i_Enable=1, counts 0..CYCLES_PER_TICK-1.
  - tick_int = i_Enable && prescaler == CYCLES_PER_TICK-1; prescaler then returns to 0.
  - CYCLES_PER_TICK=1: tick_int is high on every enabled cycle.
  - i_Enable=0: prescaler holds and tick_int = 0.
- Per-edge priority: i_Reset > i_Clear > i_Load > tick_int step > hold.
  - i_Clear=1: o_Count <= 0, prescaler <= 0, o_Tick <= 0, o_Wrap <= 0. Applies regardless of i_Enable.
  - i_Load=1 (i_Clear=0): o_Count <= i_Load_Value with any digit >9 saturated to 9; prescaler <= 0; o_Tick <= 0; o_Wrap <= 0. Applies regardless of i_Enable.
  - tick_int step: o_Count <= BCD +1 (i_Up=1) or BCD -1 (i_Up=0) with digit-wise carry/borrow; o_Tick <= 1.
    - o_Wrap <= 1 only if the step crossed the boundary: up from all-9s to all-0s, or down from all-0s to all-9s.
  - Otherwise: o_Count holds; o_Tick <= 0; o_Wrap <= 0.
  - Clear or load coinciding with tick_int suppresses the step and both pulses.
- Digit arithmetic:
  - Up: digit 9 -> 0 with carry into next digit.
  - Down: digit 0 -> 9 with borrow into next digit.
  - Carry/borrow out of the top digit is discarded and becomes the wrap.
  - No digit value >9 is ever produced.
- Latency:
  - After clear or load at edge E0 with i_Enable held high, the first step is visible after edge E0+CYCLES_PER_TICK.
  - Steps then follow every CYCLES_PER_TICK cycles.
  - Pausing preserves the partial prescaler phase.
- Reset mid-count returns everything to 0 immediately, without waiting for a clock edge.

Decomposition:
- Shared package, timer_pkg:
  - BCD_W = 4.
  - DEFAULT_CYCLES_PER_SEC = 25000000.
  - Function bcd_digit_sat (clamp a digit to 9).
  - Function bcd_step: one-digit add/sub with carry in/out, taking an up/down flag.
- Natural sub-module tick_prescaler:
  - Parameter CYCLES_PER_TICK; inputs i_Clk, i_Reset, i_Enable, i_Restart; output o_Tick.
  - o_Tick is combinational and equals tick_int above.
  - The digit chain stays in timed_bcd_counter as a generate loop over NUM_DIGITS.

Test Plan (CYCLES_PER_TICK=4, NUM_DIGITS=2 unless stated):
- Reset, then i_Enable=1, i_Up=1 for 40 cycles -> o_Count steps 00,01,..,10 every 4 cycles; o_Tick high one cycle per step; o_Wrap never high.
- Load 0x98, up, enabled -> 99 after 4 cycles, then 00 after another 4 with o_Tick=o_Wrap=1 in that cycle; load 0x01 with i_Up=0 -> 00, then 99 with o_Wrap=1.
- Drop i_Enable for 10 cycles after 2 prescaler cycles -> o_Count frozen; the next step occurs exactly 2 enabled cycles after re-enable.
- Assert i_Clear and i_Load (0x55) in the same cycle as a tick -> o_Count=00, o_Tick=0; i_Load alone with value 0xA3 -> o_Count=0x93.
- Assert i_Reset asynchronously between edges mid-count -> o_Count=00 and o_Tick=0 before the next edge; counting resumes 4 cycles after release.
- CYCLES_PER_TICK=1, NUM_DIGITS=3, up from 997 -> 998, 999, 000 on consecutive cycles; o_Wrap high only in the 000 cycle; o_Tick continuously high.

Source files
------------

// File: rtl/timer_pkg.sv
// Shared BCD helpers and constants for the timer blocks.
package timer_pkg;

    localparam int BCD_W                  = 4;
    localparam int DEFAULT_CYCLES_PER_SEC = 25000000;

    function automatic logic [BCD_W-1:0] bcd_digit_sat(input logic [BCD_W-1:0] i_Digit);
        return (i_Digit > 4'd9) ? 4'd9 : i_Digit;
    endfunction

    // Returns {carry/borrow out, next digit}; a clear carry-in leaves the digit untouched.
    function automatic logic [BCD_W:0] bcd_step(input logic [BCD_W-1:0] i_Digit,
                                                input logic             i_Up,
                                                input logic             i_Cin);
        logic [BCD_W:0] v_Res;
        v_Res = {1'b0, i_Digit};
        if (i_Cin) begin
            if (i_Up)
                v_Res = (i_Digit >= 4'd9) ? {1'b1, 4'd0} : {1'b0, i_Digit + 4'd1};
            else
                v_Res = (i_Digit == 4'd0) ? {1'b1, 4'd9} : {1'b0, i_Digit - 4'd1};
        end
        return v_Res;
    endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Divides i_Clk into a one-cycle step strobe; the phase is kept across pauses.
module tick_prescaler #(
    parameter int CYCLES_PER_TICK = 25000000
) (
    input  logic i_Clk,
    input  logic i_Reset,
    input  logic i_Enable,
    input  logic i_Restart,
    output logic o_Tick
);

    localparam int            W    = (CYCLES_PER_TICK > 1) ? $clog2(CYCLES_PER_TICK) : 1;
    localparam logic [W-1:0]  LAST = W'(CYCLES_PER_TICK - 1);

    logic [W-1:0] r_Count;

    assign o_Tick = i_Enable && (r_Count == LAST);

    always_ff @(posedge i_Clk or posedge i_Reset) begin
        if (i_Reset)
            r_Count <= '0;
        else if (i_Restart)
            r_Count <= '0;
        else if (o_Tick)
            r_Count <= '0;
        else if (i_Enable)
            r_Count <= r_Count + W'(1);
    end

endmodule

// File: rtl/timed_bcd_counter.sv
// N-digit BCD up/down counter stepped by a prescaled tick, with clear, load and wrap pulse.
module timed_bcd_counter
    import timer_pkg::*;
#(
    parameter int CYCLES_PER_TICK = DEFAULT_CYCLES_PER_SEC,
    parameter int NUM_DIGITS      = 2
) (
    input  logic                        i_Clk,
    input  logic                        i_Reset,
    input  logic                        i_Enable,
    input  logic                        i_Up,
    input  logic                        i_Clear,
    input  logic                        i_Load,
    input  logic [BCD_W*NUM_DIGITS-1:0] i_Load_Value,
    output logic [BCD_W*NUM_DIGITS-1:0] o_Count,
    output logic                        o_Tick,
    output logic                        o_Wrap
);

    logic [BCD_W*NUM_DIGITS-1:0] r_Count;
    logic                        r_Tick;
    logic                        r_Wrap;
    logic [BCD_W*NUM_DIGITS-1:0] w_Next;
    logic [BCD_W*NUM_DIGITS-1:0] w_Load_Sat;
    logic [NUM_DIGITS-1:0]       w_AtLimit;
    logic [NUM_DIGITS-1:0]       w_Cout;
    logic                        w_Step;
    logic                        w_Wrap;

    tick_prescaler #(
        .CYCLES_PER_TICK(CYCLES_PER_TICK)
    ) u_prescaler (
        .i_Clk    (i_Clk),
        .i_Reset  (i_Reset),
        .i_Enable (i_Enable),
        .i_Restart(i_Clear | i_Load),
        .o_Tick   (w_Step)
    );

    // Carry into digit k is the AND of the lower digits' limit flags, so no
    // combinational chain runs through the digit results themselves.
    for (genvar k = 0; k < NUM_DIGITS; k++) begin : g_digit
        logic w_Cin;

        assign w_AtLimit[k] = i_Up ? (r_Count[BCD_W*k +: BCD_W] >= 4'd9)
                                   : (r_Count[BCD_W*k +: BCD_W] == 4'd0);
        if (k == 0) begin : g_lsd
            assign w_Cin = 1'b1;
        end else begin : g_upper
            assign w_Cin = &w_AtLimit[k-1:0];
        end

        assign {w_Cout[k], w_Next[BCD_W*k +: BCD_W]} =
            bcd_step(r_Count[BCD_W*k +: BCD_W], i_Up, w_Cin);
        assign w_Load_Sat[BCD_W*k +: BCD_W] = bcd_digit_sat(i_Load_Value[BCD_W*k +: BCD_W]);
    end

    // Every digit carries out only when all digits sit at the limit: that is the wrap.
    assign w_Wrap = &w_Cout;

    always_ff @(posedge i_Clk or posedge i_Reset) begin
        if (i_Reset) begin
            r_Count <= '0;
            r_Tick  <= 1'b0;
            r_Wrap  <= 1'b0;
        end else if (i_Clear) begin
            r_Count <= '0;
            r_Tick  <= 1'b0;
            r_Wrap  <= 1'b0;
        end else if (i_Load) begin
            r_Count <= w_Load_Sat;
            r_Tick  <= 1'b0;
            r_Wrap  <= 1'b0;
        end else if (w_Step) begin
            r_Count <= w_Next;
            r_Tick  <= 1'b1;
            r_Wrap  <= w_Wrap;
        end else begin
            r_Tick  <= 1'b0;
            r_Wrap  <= 1'b0;
        end
    end

    assign o_Count = r_Count;
    assign o_Tick  = r_Tick;
    assign o_Wrap  = r_Wrap;

endmodule

// File: tb/tb_timed_bcd_counter.sv
// Directed bench: a 4-cycle/2-digit instance and a 1-cycle/3-digit instance.
module tb_timed_bcd_counter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_a, en_a, up_a, clr_a, ld_a;
    logic [7:0] ldv_a, cnt_a;
    logic       tick_a, wrap_a;

    logic        rst_b, en_b, up_b, clr_b, ld_b;
    logic [11:0] ldv_b, cnt_b;
    logic        tick_b, wrap_b;

    int n_cmp  = 0;
    int n_fail = 0;

    timed_bcd_counter #(.CYCLES_PER_TICK(4), .NUM_DIGITS(2)) dut_a (
        .i_Clk(clk), .i_Reset(rst_a), .i_Enable(en_a), .i_Up(up_a),
        .i_Clear(clr_a), .i_Load(ld_a), .i_Load_Value(ldv_a),
        .o_Count(cnt_a), .o_Tick(tick_a), .o_Wrap(wrap_a)
    );

    timed_bcd_counter #(.CYCLES_PER_TICK(1), .NUM_DIGITS(3)) dut_b (
        .i_Clk(clk), .i_Reset(rst_b), .i_Enable(en_b), .i_Up(up_b),
        .i_Clear(clr_b), .i_Load(ld_b), .i_Load_Value(ldv_b),
        .o_Count(cnt_b), .o_Tick(tick_b), .o_Wrap(wrap_b)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and settle just after it.
    task automatic edge1();
        @(posedge clk);
        #1;
    endtask

    task automatic edges(input int n);
        for (int i = 0; i < n; i++) edge1();
    endtask

    task automatic chk_a(input string tag, input logic [7:0] c, input logic t, input logic w);
        chk({tag, ".count"}, 32'(cnt_a), 32'(c));
        chk({tag, ".tick"},  32'(tick_a), 32'(t));
        chk({tag, ".wrap"},  32'(wrap_a), 32'(w));
    endtask

    task automatic chk_b(input string tag, input logic [11:0] c, input logic t, input logic w);
        chk({tag, ".count"}, 32'(cnt_b), 32'(c));
        chk({tag, ".tick"},  32'(tick_b), 32'(t));
        chk({tag, ".wrap"},  32'(wrap_b), 32'(w));
    endtask

    initial begin
        logic [7:0] exp_c;
        int         v;

        rst_a = 1'b1; en_a = 1'b0; up_a = 1'b1; clr_a = 1'b0; ld_a = 1'b0; ldv_a = 8'h00;
        rst_b = 1'b1; en_b = 1'b0; up_b = 1'b1; clr_b = 1'b0; ld_b = 1'b0; ldv_b = 12'h000;
        #2;
        chk_a("reset_a", 8'h00, 1'b0, 1'b0);
        chk_b("reset_b", 12'h000, 1'b0, 1'b0);
        edges(2);
        rst_a = 1'b0; rst_b = 1'b0;

        // Count up 40 cycles: one step every 4th edge, 00..10.
        en_a = 1'b1; up_a = 1'b1;
        for (int c = 1; c <= 40; c++) begin
            edge1();
            v = c / 4;
            exp_c = {4'(v / 10), 4'(v % 10)};
            chk_a($sformatf("up40_c%0d", c), exp_c, (c % 4) == 0, 1'b0);
        end

        // Load 98, step to 99, then wrap to 00.
        ld_a = 1'b1; ldv_a = 8'h98;
        edge1();
        ld_a = 1'b0;
        chk_a("load98", 8'h98, 1'b0, 1'b0);
        edges(3);
        chk_a("load98_pre", 8'h98, 1'b0, 1'b0);
        edge1();
        chk_a("step99", 8'h99, 1'b1, 1'b0);
        edges(4);
        chk_a("wrap_up", 8'h00, 1'b1, 1'b1);
        edge1();
        chk_a("wrap_up_after", 8'h00, 1'b0, 1'b0);

        // Load 01 counting down: 00, then wrap to 99.
        up_a = 1'b0; ld_a = 1'b1; ldv_a = 8'h01;
        edge1();
        ld_a = 1'b0;
        chk_a("load01", 8'h01, 1'b0, 1'b0);
        edges(4);
        chk_a("down00", 8'h00, 1'b1, 1'b0);
        edges(4);
        chk_a("wrap_down", 8'h99, 1'b1, 1'b1);

        // Pause after 2 prescaler cycles; phase is kept.
        edges(2);
        en_a = 1'b0;
        edges(10);
        chk_a("paused", 8'h99, 1'b0, 1'b0);
        en_a = 1'b1;
        edge1();
        chk_a("resume1", 8'h99, 1'b0, 1'b0);
        edge1();
        chk_a("resume2", 8'h98, 1'b1, 1'b0);

        // Clear + load on a tick cycle: clear wins, no step or pulse.
        edges(3);
        clr_a = 1'b1; ld_a = 1'b1; ldv_a = 8'h55;
        edge1();
        clr_a = 1'b0; ld_a = 1'b0;
        chk_a("clr_ld_tick", 8'h00, 1'b0, 1'b0);

        // Load with a non-BCD digit saturates it to 9.
        ld_a = 1'b1; ldv_a = 8'hA3; up_a = 1'b1;
        edge1();
        ld_a = 1'b0;
        chk_a("load_sat", 8'h93, 1'b0, 1'b0);
        edges(3);
        chk_a("sat_pre", 8'h93, 1'b0, 1'b0);
        edge1();
        chk_a("sat_step", 8'h94, 1'b1, 1'b0);

        // Async reset right after a step, between edges.
        edges(4);
        chk_a("pre_rst", 8'h95, 1'b1, 1'b0);
        #2 rst_a = 1'b1;
        #1;
        chk_a("async_rst", 8'h00, 1'b0, 1'b0);
        edge1();
        rst_a = 1'b0;
        edges(3);
        chk_a("post_rst_pre", 8'h00, 1'b0, 1'b0);
        edge1();
        chk_a("post_rst_step", 8'h01, 1'b1, 1'b0);

        // One-cycle tick, 3 digits, wrapping from 997.
        ld_b = 1'b1; ldv_b = 12'h997;
        edge1();
        ld_b = 1'b0; en_b = 1'b1; up_b = 1'b1;
        chk_b("b_load", 12'h997, 1'b0, 1'b0);
        edge1();
        chk_b("b_998", 12'h998, 1'b1, 1'b0);
        edge1();
        chk_b("b_999", 12'h999, 1'b1, 1'b0);
        edge1();
        chk_b("b_000", 12'h000, 1'b1, 1'b1);
        edge1();
        chk_b("b_001", 12'h001, 1'b1, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
